// File: rtl/eth_encap_pkg.sv
// Shared types, FIFO entry layout and header layout for the tap-FIFO Ethernet encapsulator.
package eth_encap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR0    = 2'd1,
        HDR1    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    // Tap FIFO entry: [63:0] data, [71:64] keep, [72] last, [73] user
    localparam int ENTRY_W      = 74;
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_KEEP_LSB = 64;
    localparam int ENT_LAST_BIT = 72;
    localparam int ENT_USER_BIT = 73;

    localparam int HDR_BEATS = 2;

    // Byte offsets inside the two header beats (byte 0 is tdata[7:0])
    localparam int HDR0_DST_BYTE   = 0;
    localparam int HDR0_SRC_BYTE   = 6;
    localparam int HDR1_SRC_BYTE   = 0;
    localparam int HDR1_ETYPE_BYTE = 4;
    localparam int HDR1_CTRL_BYTE  = 6;
    localparam int HDR1_SEQ_BYTE   = 7;

    // One AXI-S beat; field order matches the FIFO entry bit layout
    typedef struct packed {
        logic       user;
        logic       last;
        logic [7:0] keep;
        logic [63:0] data;
    } beat_t;

    // First header beat: full destination MAC then the top two source MAC bytes, MSB first
    function automatic logic [63:0] build_hdr0(input logic [47:0] dst, input logic [47:0] src);
        logic [63:0] h;
        h = '0;
        for (int b = 0; b < 6; b++) begin
            h[(HDR0_DST_BYTE + b)*8 +: 8] = dst[(5 - b)*8 +: 8];
        end
        for (int b = 0; b < 2; b++) begin
            h[(HDR0_SRC_BYTE + b)*8 +: 8] = src[(5 - b)*8 +: 8];
        end
        return h;
    endfunction

    // Second header beat: rest of source MAC, EtherType, control byte and sequence number
    function automatic logic [63:0] build_hdr1(input logic [47:0] src, input logic [15:0] etype,
                                               input logic cont, input logic [3:0] ch,
                                               input logic [7:0] seq);
        logic [63:0] h;
        h = '0;
        for (int b = 0; b < 4; b++) begin
            h[(HDR1_SRC_BYTE + b)*8 +: 8] = src[(3 - b)*8 +: 8];
        end
        h[HDR1_ETYPE_BYTE*8 +: 8]       = etype[15:8];
        h[(HDR1_ETYPE_BYTE + 1)*8 +: 8] = etype[7:0];
        h[HDR1_CTRL_BYTE*8 +: 8]        = {cont, 3'b000, ch};
        h[HDR1_SEQ_BYTE*8 +: 8]         = seq;
        return h;
    endfunction

endpackage

// File: rtl/eth_axis_skid.sv
// Two-entry registered skid buffer; s_ready comes from a flop so downstream ready never reaches upstream pops.
module eth_axis_skid
    import eth_encap_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  s_valid,
    output logic  s_ready,
    input  beat_t s_beat,
    output logic  m_valid,
    input  logic  m_ready,
    output beat_t m_beat
);

    beat_t out_q;
    beat_t skid_q;
    logic  out_v;
    logic  skid_v;

    assign s_ready = ~skid_v;
    assign m_valid = out_v;
    assign m_beat  = out_q;

    // Output register is fed directly so an accepted beat is visible next cycle; the skid slot only fills under back-pressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_v && m_ready) begin
            if (skid_v) begin
                out_q  <= skid_q;
                skid_v <= 1'b0;
            end else if (s_valid) begin
                out_q <= s_beat;
            end else begin
                out_v <= 1'b0;
            end
        end else if (!out_v) begin
            if (s_valid) begin
                out_q <= s_beat;
                out_v <= 1'b1;
            end
        end else if (s_valid && !skid_v) begin
            skid_q <= s_beat;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/tlp_eth_encap_mux.sv
// Round-robin multiplexer that wraps tap FIFO payloads into Ethernet frames for a 10G MAC.
module tlp_eth_encap_mux
    import eth_encap_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          MAX_BEATS = 184,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic                             clk156,
    input  logic                             sys_rst,
    input  logic                             enable,
    input  logic [47:0]                      dst_mac,
    input  logic [47:0]                      src_mac,
    input  logic [NUM_CH-1:0]                empty,
    input  logic [NUM_CH-1:0][ENTRY_W-1:0]   dout,
    output logic [NUM_CH-1:0]                rd_en,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [63:0]                      m_axis_tdata,
    output logic [7:0]                       m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    output logic [31:0]                      frame_cnt,
    output logic [31:0]                      bubble_cnt
);

    // Frame beat counter covers header and payload; the forced split lands on payload beat MAX_BEATS
    localparam int               CNT_W    = $clog2(HDR_BEATS + MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_BEATS + MAX_BEATS - 1);

    state_t              state;
    state_t              state_next;
    logic [3:0]          grant;
    logic [3:0]          rr_idx;
    logic                rr_found;
    int                  rr_best;
    int                  rr_dist;
    logic [CNT_W-1:0]    beat_cnt;
    logic                err_acc;
    logic                tail_pending;
    logic                tail_done;
    logic [7:0]          seq [NUM_CH];
    logic [NUM_CH-1:0]   cont;
    logic                sel_empty;
    logic                sel_cont;
    logic [7:0]          sel_seq;
    logic [ENTRY_W-1:0]  sel_entry;
    logic                forced;
    logic                push;
    logic                pop;
    beat_t               push_beat;
    logic                skid_ready;
    beat_t               out_beat;

    assign tail_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign forced    = (beat_cnt == LAST_IDX);

    // Pick out the granted channel's FIFO head and per-channel header state
    always_comb begin
        sel_empty = 1'b1;
        sel_entry = '0;
        sel_cont  = 1'b0;
        sel_seq   = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == 4'(i)) begin
                sel_empty = empty[i];
                sel_entry = dout[i];
                sel_cont  = cont[i];
                sel_seq   = seq[i];
            end
        end
    end

    // Round-robin search: nearest non-empty channel after the last granted one
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = grant;
        rr_best  = NUM_CH;
        rr_dist  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!empty[i]) begin
                rr_dist = (i + NUM_CH - 1 - int'(grant)) % NUM_CH;
                if (rr_dist < rr_best) begin
                    rr_best  = rr_dist;
                    rr_idx   = 4'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end

    // Next state and the beat offered to the skid buffer; a new grant waits until the previous tail is handed off
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        push_beat  = '0;
        case (state)
            IDLE: begin
                if (enable && rr_found && (!tail_pending || tail_done)) begin
                    state_next = HDR0;
                end
            end
            HDR0: begin
                push_beat.data = build_hdr0(dst_mac, src_mac);
                push_beat.keep = 8'hFF;
                if (skid_ready) begin
                    push       = 1'b1;
                    state_next = HDR1;
                end
            end
            HDR1: begin
                push_beat.data = build_hdr1(src_mac, ETHERTYPE, sel_cont, grant, sel_seq);
                push_beat.keep = 8'hFF;
                if (skid_ready) begin
                    push       = 1'b1;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                push_beat.data = sel_entry[ENT_DATA_LSB +: 64];
                push_beat.keep = sel_entry[ENT_KEEP_LSB +: 8];
                push_beat.last = sel_entry[ENT_LAST_BIT] | forced;
                push_beat.user = push_beat.last & (err_acc | sel_entry[ENT_USER_BIT]);
                if (!sel_empty && skid_ready) begin
                    pop  = 1'b1;
                    push = 1'b1;
                    if (push_beat.last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pop strobe goes only to the granted channel
    always_comb begin
        rd_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_en[i] = pop && (grant == 4'(i));
        end
    end

    // FSM state, grant pointer, frame beat count and error accumulation
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            grant        <= 4'(NUM_CH - 1);
            beat_cnt     <= '0;
            err_acc      <= 1'b0;
            tail_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == HDR0) begin
                grant    <= rr_idx;
                beat_cnt <= '0;
                err_acc  <= 1'b0;
            end else if (push) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (pop) begin
                err_acc <= err_acc | sel_entry[ENT_USER_BIT];
            end
            if (push && push_beat.last) begin
                tail_pending <= 1'b1;
            end else if (tail_done) begin
                tail_pending <= 1'b0;
            end
        end
    end

    // Per-channel sequence number and continuation flag, updated when a frame's tail is committed
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            cont <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                seq[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pop && push_beat.last && grant == 4'(i)) begin
                    seq[i]  <= seq[i] + 8'd1;
                    cont[i] <= forced & ~sel_entry[ENT_LAST_BIT];
                end
            end
        end
    end

    // Emitted-frame and FIFO-starvation counters
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (tail_done) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (state == PAYLOAD && sel_empty) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    eth_axis_skid u_skid (
        .clk     (clk156),
        .rst     (sys_rst),
        .s_valid (push),
        .s_ready (skid_ready),
        .s_beat  (push_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_beat  (out_beat)
    );

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tkeep = out_beat.keep;
    assign m_axis_tlast = out_beat.last;
    assign m_axis_tuser = out_beat.user;

endmodule

// File: tb/tb_tlp_eth_encap_mux.sv
// Scoreboard bench for tlp_eth_encap_mux: FIFO models feed the DUT, expected beats are queued at load time.
module tb_tlp_eth_encap_mux;

    localparam int          NUM_CH    = 2;
    localparam int          MAX_BEATS = 184;
    localparam logic [15:0] ETYPE     = 16'h88B5;

    logic                      clk156 = 1'b0;
    logic                      sys_rst = 1'b1;
    logic                      enable = 1'b0;
    logic [47:0]               dst_mac = 48'h0102_0304_0506;
    logic [47:0]               src_mac = 48'h0A0B_0C0D_0E0F;
    logic [NUM_CH-1:0]         empty = '1;
    logic [NUM_CH-1:0][73:0]   dout = '0;
    logic [NUM_CH-1:0]         rd_en;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready = 1'b1;
    logic [63:0]               m_axis_tdata;
    logic [7:0]                m_axis_tkeep;
    logic                      m_axis_tlast;
    logic                      m_axis_tuser;
    logic [31:0]               frame_cnt;
    logic [31:0]               bubble_cnt;

    tlp_eth_encap_mux #(.NUM_CH(NUM_CH), .MAX_BEATS(MAX_BEATS), .ETHERTYPE(ETYPE)) dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .empty         (empty),
        .dout          (dout),
        .rd_en         (rd_en),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_cnt     (frame_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #3 clk156 = ~clk156;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [73:0]  fq0[$];
    logic [73:0]  fq1[$];
    logic [73:0]  exp_q[$];
    int           len_q[$];
    logic [7:0]   ctrl_q[$];
    int           pops0 = 0;
    int           stall_at = 0;
    int           stall_left = 0;
    logic         stall_armed = 1'b0;
    logic         bp_mode = 1'b0;
    logic         lat_en = 1'b0;
    logic [1:0]   pop_pend = '0;
    logic         popped_flag = 1'b0;
    logic [63:0]  popped_data = '0;
    int           cur_len = 0;
    int           gaps = 0;
    int           m_seq [2];
    logic [1:0]   m_cont = '0;

    task automatic checkOutput(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] exp_hdr0();
        return {1'b0, 1'b0, 8'hFF, src_mac[39:32], src_mac[47:40], dst_mac[7:0], dst_mac[15:8],
                dst_mac[23:16], dst_mac[31:24], dst_mac[39:32], dst_mac[47:40]};
    endfunction

    function automatic logic [73:0] exp_hdr1(input logic cont, input int ch, input int seq);
        logic [3:0] chn;
        chn = 4'(ch);
        return {1'b0, 1'b0, 8'hFF, 8'(seq), {cont, 3'b000, chn}, ETYPE[7:0], ETYPE[15:8],
                src_mac[7:0], src_mac[15:8], src_mac[23:16], src_mac[31:24]};
    endfunction

    // Push n entries into channel ch's FIFO model and queue the frame(s) they should produce
    task automatic applyStimulus(input int ch, input int n, input int user_pos, input logic [7:0] last_keep);
        logic [73:0] e;
        logic [63:0] d;
        logic        lst, usr, fl, acc;
        logic [7:0]  kp;
        int          cnt;
        bit          in_frame;
        in_frame = 0;
        cnt = 0;
        acc = 1'b0;
        for (int k = 1; k <= n; k++) begin
            d   = {$urandom(), $urandom()};
            lst = (k == n);
            usr = (k == user_pos);
            kp  = lst ? last_keep : 8'hFF;
            e   = {usr, lst, kp, d};
            if (ch == 0) fq0.push_back(e); else fq1.push_back(e);
            if (!in_frame) begin
                exp_q.push_back(exp_hdr0());
                exp_q.push_back(exp_hdr1(m_cont[ch], ch, m_seq[ch]));
                in_frame = 1;
                cnt = 0;
                acc = 1'b0;
            end
            cnt++;
            acc = acc | usr;
            fl  = lst || (cnt == MAX_BEATS);
            exp_q.push_back({fl & acc, fl, kp, d});
            if (fl) begin
                m_cont[ch] = ~lst;
                m_seq[ch]  = (m_seq[ch] + 1) % 256;
                in_frame   = 0;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || fq0.size() != 0 || fq1.size() != 0) && c < budget) begin
            @(posedge clk156);
            c++;
        end
        checkOutput({tag, "_drain_left"}, 74'(exp_q.size()), 74'd0);
        repeat (4) @(posedge clk156);
        #2;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        enable  = 1'b0;
        fq0.delete();
        fq1.delete();
        exp_q.delete();
        m_seq[0] = 0;
        m_seq[1] = 0;
        m_cont   = '0;
        repeat (3) @(posedge clk156);
        #2;
        sys_rst = 1'b0;
        @(posedge clk156);
        #2;
    endtask

    // FIFO model: apply pops granted at the previous edge, then present head/empty and tready
    always @(posedge clk156) begin
        #1;
        popped_flag = 1'b0;
        if (pop_pend[0] && fq0.size() > 0) begin
            popped_data = fq0[0][63:0];
            popped_flag = 1'b1;
            void'(fq0.pop_front());
            pops0++;
        end
        if (pop_pend[1] && fq1.size() > 0) begin
            popped_data = fq1[0][63:0];
            popped_flag = 1'b1;
            void'(fq1.pop_front());
        end
        if (stall_left > 0) stall_left--;
        if (stall_armed && pops0 == stall_at) begin
            stall_armed = 1'b0;
            stall_left  = 4;
        end
        empty[0] = (fq0.size() == 0) || (stall_left > 0);
        empty[1] = (fq1.size() == 0);
        dout[0]  = (fq0.size() != 0) ? fq0[0] : 74'd0;
        dout[1]  = (fq1.size() != 0) ? fq1[0] : 74'd0;
        m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard compare on every handshake, plus pop legality and pop-to-output latency
    always @(negedge clk156) begin
        logic [73:0] ex;
        pop_pend = rd_en;
        if (|rd_en) checkOutput("rd_en_on_empty", 74'(rd_en & empty), 74'd0);
        if (lat_en && popped_flag) checkOutput("pop_latency", {9'd0, m_axis_tvalid, m_axis_tdata}, {9'd0, 1'b1, popped_data});
        if (sys_rst) begin
            cur_len = 0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 74'd1, 74'd0);
            end else begin
                ex = exp_q.pop_front();
                checkOutput("beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, ex);
            end
            cur_len++;
            if (cur_len == 2) ctrl_q.push_back(m_axis_tdata[55:48]);
            if (m_axis_tlast) begin
                len_q.push_back(cur_len);
                cur_len = 0;
            end
        end else if (cur_len > 0) begin
            gaps++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int bub0;
        m_seq[0] = 0;
        m_seq[1] = 0;

        // Reset values while reset is held
        #10;
        checkOutput("rst_tvalid", 74'(m_axis_tvalid), 74'd0);
        checkOutput("rst_tdata", 74'(m_axis_tdata), 74'd0);
        checkOutput("rst_tkeep_tlast_tuser", 74'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 74'd0);
        checkOutput("rst_rd_en", 74'(rd_en), 74'd0);
        checkOutput("rst_counters", 74'({frame_cnt, bubble_cnt}), 74'd0);
        do_reset();

        // Basic 3-entry frame on ch0 with short final keep, full-rate tready
        lat_en = 1'b1;
        len_q.delete();
        gaps = 0;
        applyStimulus(0, 3, 0, 8'h0F);
        @(posedge clk156);
        enable = 1'b1;
        wait_done("fmt", 200);
        checkOutput("fmt_frame_len", 74'(len_q.size() > 0 ? len_q[0] : -1), 74'd5);
        checkOutput("fmt_frame_cnt", 74'(frame_cnt), 74'd1);
        checkOutput("fmt_no_gaps", 74'(gaps), 74'd0);

        // Starve ch0 for 4 cycles after the second pop of a 5-entry frame
        bub0 = bubble_cnt;
        stall_at = pops0 + 2;
        stall_armed = 1'b1;
        applyStimulus(0, 5, 0, 8'hFF);
        wait_done("bubble", 300);
        checkOutput("bubble_delta", 74'(bubble_cnt - bub0), 74'd4);
        checkOutput("bubble_frame_cnt", 74'(frame_cnt), 74'd2);

        // Error flag on the middle entry shows only on the tail beat
        applyStimulus(0, 3, 2, 8'hFF);
        wait_done("err", 200);
        checkOutput("err_frame_cnt", 74'(frame_cnt), 74'd3);

        // Round-robin after reset: both channels hold three 1-entry frames
        do_reset();
        checkOutput("rr_frame_cnt_after_rst", 74'(frame_cnt), 74'd0);
        ctrl_q.delete();
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1, 0, 8'hFF);
            applyStimulus(1, 1, 0, 8'hFF);
        end
        @(posedge clk156);
        enable = 1'b1;
        wait_done("rr", 300);
        for (int r = 0; r < 6; r++) begin
            checkOutput("rr_grant_order", 74'(ctrl_q.size() > r ? int'(ctrl_q[r]) : -1), 74'(r % 2));
        end

        // Forced split of a 200-entry ch1 message under random back-pressure
        do_reset();
        lat_en  = 1'b0;
        bp_mode = 1'b1;
        len_q.delete();
        ctrl_q.delete();
        applyStimulus(1, 200, 0, 8'hFF);
        @(posedge clk156);
        enable = 1'b1;
        wait_done("split", 3000);
        checkOutput("split_lenA", 74'(len_q.size() > 0 ? len_q[0] : -1), 74'(MAX_BEATS + 2));
        checkOutput("split_lenB", 74'(len_q.size() > 1 ? len_q[1] : -1), 74'(16 + 2));
        checkOutput("split_ctrlA", 74'(ctrl_q.size() > 0 ? ctrl_q[0] : 8'hEE), 74'h01);
        checkOutput("split_ctrlB", 74'(ctrl_q.size() > 1 ? ctrl_q[1] : 8'hEE), 74'h81);
        checkOutput("split_frame_cnt", 74'(frame_cnt), 74'd2);
        bp_mode = 1'b0;

        // Reset in the middle of a ch0 payload
        do_reset();
        applyStimulus(0, 8, 0, 8'hFF);
        bub0 = pops0;
        @(posedge clk156);
        enable = 1'b1;
        c = 0;
        while (pops0 < bub0 + 2 && c < 200) begin
            @(posedge clk156);
            #2;
            c++;
        end
        checkOutput("midrst_reached_payload", 74'(c < 200), 74'd1);
        sys_rst = 1'b1;
        #1;
        checkOutput("midrst_tvalid_async", 74'(m_axis_tvalid), 74'd0);
        fq0.delete();
        exp_q.delete();
        m_seq[0] = 0;
        m_seq[1] = 0;
        m_cont   = '0;
        repeat (2) @(posedge clk156);
        #2;
        sys_rst = 1'b0;
        repeat (3) @(posedge clk156);
        #2;
        checkOutput("midrst_frame_cnt", 74'(frame_cnt), 74'd0);
        ctrl_q.delete();
        applyStimulus(0, 1, 0, 8'hFF);
        applyStimulus(1, 1, 0, 8'hFF);
        wait_done("postrst", 200);
        checkOutput("postrst_first_grant", 74'(ctrl_q.size() > 0 ? ctrl_q[0] : 8'hEE), 74'h00);
        checkOutput("postrst_frame_cnt", 74'(frame_cnt), 74'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlp_eth_encap_mux.md
TLP_ETH_ENCAP_MUX -- requirements
Module: tlp_eth_encap_mux

Interface
REQ-001 Parameters, one per line:
- NUM_CH, 2, tap FIFO channels, 1..16.
- MAX_BEATS, 184, payload beats per frame before forced split (184 x 8 B = 1472 B).
- ETHERTYPE, 16'h88B5, EtherType placed in the header.
REQ-002 Ports, one per line:
- clk156  in  1  sole clock, 156.25 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits new frame grants.
- dst_mac  in  48  destination MAC, quasi-static.
- src_mac  in  48  source MAC, quasi-static.
- empty  in  NUM_CH  per-channel FWFT FIFO empty.
- dout  in  NUM_CH x 74  per-channel FIFO head entry.
- rd_en  out  NUM_CH  per-channel FIFO pop.
- m_axis_tvalid  out  1  AXI-S valid to the 10G MAC.
- m_axis_tready  in  1  AXI-S ready.
- m_axis_tdata  out  64  AXI-S data; byte 0 is tdata[7:0].
- m_axis_tkeep  out  8  AXI-S keep.
- m_axis_tlast  out  1  AXI-S last.
- m_axis_tuser  out  1  AXI-S error, meaningful on tlast only.
- frame_cnt  out  32  count of emitted frames, wraps.
- bubble_cnt  out  32  count of in-frame cycles stalled on an empty FIFO, wraps.
REQ-003 The clock is clk156 and the reset is sys_rst, asynchronous and active-high; there are no other clocks.

Function
REQ-004 FIFO entry layout: [63:0] data, [71:64] keep, [72] last, [73] user; the FIFOs are first-word-fall-through, so dout is valid whenever empty=0 and rd_en=1 pops the entry.
REQ-005 FSM states: IDLE, HDR0, HDR1, PAYLOAD.
REQ-006 IDLE -> HDR0 when enable=1 and any empty[i]=0; the grant goes round-robin to the first non-empty channel after the last granted one.
REQ-007 The grant is held unchanged from HDR0 until the tlast beat is accepted.
REQ-008 HDR0 beat, bytes 0-5: dst_mac[47:40] down to dst_mac[7:0]. Bytes 6-7: src_mac[47:40], src_mac[39:32]. tkeep=8'hFF.
REQ-009 HDR1 beat, bytes 0-3: src_mac[31:0], MSB first. Bytes 4-5: ETHERTYPE, MSB first. Byte 6: {cont, 3'b000, ch[3:0]}. Byte 7: seq[ch]. tkeep=8'hFF.
REQ-010 PAYLOAD: each accepted beat carries one popped entry, with data and keep passed through unchanged.
REQ-011 The frame ends (tlast=1, then -> IDLE) on the first entry with last=1, or on payload beat MAX_BEATS.
REQ-012 After a forced split the channel's cont flag is set to 1 for its next frame; a natural last clears it to 0.
REQ-013 seq[ch] is 8 bits, increments by 1 on each tlast accepted for ch, and wraps 255 -> 0.
REQ-014 m_axis_tuser=1 on the tlast beat iff any payload entry of that frame had user=1.
REQ-015 rd_en[g] is asserted only in PAYLOAD, only when empty[g]=0 and the skid stage can accept; it is never asserted for a non-granted channel.
REQ-016 In PAYLOAD with empty[g]=1 no beat is produced and bubble_cnt increments once per cycle.
REQ-017 enable=0 mid-frame does not truncate the frame; only new grants are blocked.
REQ-018 Latency: a FIFO pop appears on m_axis exactly 1 cycle later when tready=1.
REQ-019 No beat is lost or duplicated under arbitrary tready back-pressure.
REQ-020 frame_cnt increments once per accepted tlast beat.
REQ-021 The earliest next grant is the cycle after the tlast handshake; there are no idle beats inside header or payload other than those caused by an empty FIFO.

Reset
REQ-022 During reset:
- FSM returns to IDLE.
- Round-robin pointer is set so channel 0 is granted first.
- All seq and cont values clear to 0.
- frame_cnt and bubble_cnt clear to 0.
- rd_en=0, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0.
REQ-023 Reset mid-frame drops tvalid asynchronously and discards the skid contents; the truncated frame is not counted.

Structure
REQ-024 Package eth_encap_pkg holds:
- the FSM state enum;
- the FIFO entry field positions and 74-bit width;
- HDR_BEATS=2;
- the header byte offsets.
REQ-025 Sub-module eth_axis_skid, a 2-entry registered skid buffer, provides REQ-018 and breaks the tready-to-rd_en combinational path.

Verification
REQ-026 Frame format: NUM_CH=2, ch0 holds 3 entries, last on the third with keep 8'h0F, tready=1 -> exactly 5 beats (HDR0, HDR1, 3 payload); tlast on beat 5 with tkeep 8'h0F; byte 6 of HDR1 = 8'h00; seq byte = 0; frame_cnt=1.
REQ-027 Round-robin: both channels continuously hold 1-entry frames -> grant order 0,1,0,1; each channel's seq increments 0,1,2.
REQ-028 Forced split: ch1 holds 200 entries with last on entry 200 ->
- frame A: 184 payload beats, tlast, cont=0 in its header;
- frame B: 16 payload beats, HDR1 byte 6 = 8'h81.
REQ-029 Back-pressure and stall:
- tready toggling randomly 50% -> output payload matches the FIFO input bit-exact and in order;
- empty=1 for 4 cycles mid-frame -> bubble_cnt += 4.
REQ-030 Error and reset:
- user=1 on the middle entry of a 3-entry frame -> tuser=1 on tlast only;
- sys_rst asserted mid-payload -> tvalid=0 at once, frame_cnt unchanged, ch0 granted first after release.
